// File: rtl/cheri_pkg.sv
// cheri_pkg: shared types for the CHERI data-memory responder.
//   dmem_rsp_t       - one response pipeline stage {valid, err, rdata[32:0]}
//   DMEM_MAX_LATENCY - upper bound of the responder's grant-to-rvalid latency
//   dmem_state_e     - responder FSM states (tag sweep, then serving)
package cheri_pkg;

  localparam int unsigned DMEM_MAX_LATENCY = 4;

  typedef enum logic [0:0] {
    DMEM_INIT,
    DMEM_READY
  } dmem_state_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [32:0] rdata;
  } dmem_rsp_t;

endpackage

// File: rtl/cheri_dmem_tagarray.sv
// cheri_dmem_tagarray: one capability tag bit per memory word.
//   clk_i             clock
//   clr_en_i/clr_idx_i sweep-clear port, clears one tag per cycle
//   we_i/widx_i/wtag_i tag write port (sweep clear takes priority)
//   ridx_i/rtag_o     asynchronous tag read port
// Tags are not reset; the owner clears them with the sweep port.
module cheri_dmem_tagarray #(
  parameter int unsigned AddrW = 12
) (
  input  logic             clk_i,
  input  logic             clr_en_i,
  input  logic [AddrW-1:0] clr_idx_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] widx_i,
  input  logic             wtag_i,
  input  logic [AddrW-1:0] ridx_i,
  output logic             rtag_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic tags_q [Depth];

  always_ff @(posedge clk_i) begin
    if (clr_en_i) begin
      tags_q[clr_idx_i] <= 1'b0;
    end else if (we_i) begin
      tags_q[widx_i] <= wtag_i;
    end
  end

  assign rtag_o = tags_q[ridx_i];

endmodule

// File: rtl/cheri_dmem_responder.sv
// cheri_dmem_responder: responder end of the core data memory interface.
// Word SRAM plus per-word capability tags, fixed-latency responses.
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   data_req_i/data_gnt_o  request handshake, same-cycle grant
//   data_we_i, data_be_i   store flag and byte enables
//   data_addr_i            byte address, bits [1:0] ignored
//   data_wdata_i           bit 32 = tag, bits [31:0] = data
//   data_is_cap_i          capability access (qualifies tag read/write)
//   data_rvalid_o, data_rdata_o, data_err_o  response, Latency cycles after grant
//   data_rdata_intg_o      tied to zero
//   init_done_o            tag sweep after reset has completed
// Optional build macro: CHERI_DMEM_RAND_STALL_EN adds LFSR-driven grant stalls.
module cheri_dmem_responder
  import cheri_pkg::*;
#(
  parameter int unsigned MemAddrW = 12,
  parameter logic [31:0] BaseAddr = 32'h2000_0000,
  parameter int unsigned Latency  = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [32:0] data_wdata_i,
  input  logic        data_is_cap_i,
  output logic        data_rvalid_o,
  output logic [32:0] data_rdata_o,
  output logic [6:0]  data_rdata_intg_o,
  output logic        data_err_o,
  output logic        init_done_o
);

  localparam int unsigned Depth     = 1 << MemAddrW;
  localparam int unsigned LastStage = Latency - 1;
  localparam logic [31:0] WinMask   = 32'((64'd1 << (MemAddrW + 2)) - 64'd1);

  dmem_state_e         state_q;
  logic [MemAddrW-1:0] sweep_idx_q;
  logic                init_done_q;
  logic                ready;
  logic                stall;
  logic                gnt;
  logic                in_range;
  logic [MemAddrW-1:0] idx;
  logic                wr_en;
  logic                rd_en;
  logic                rtag;
  logic [31:0]         mem_q [Depth];
  dmem_rsp_t           rsp_d;
  dmem_rsp_t           pipe_q [Latency];

  // Tag sweep FSM: one tag cleared per cycle, then serve requests forever.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= DMEM_INIT;
      sweep_idx_q <= '0;
      init_done_q <= 1'b0;
    end else if (state_q == DMEM_INIT) begin
      if (sweep_idx_q == '1) begin
        state_q     <= DMEM_READY;
        init_done_q <= 1'b1;
      end else begin
        sweep_idx_q <= sweep_idx_q + 1'b1;
      end
    end
  end

  assign ready = (state_q == DMEM_READY);

`ifdef CHERI_DMEM_RAND_STALL_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Fibonacci LFSR, taps 16/14/13/11; only advances while serving.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= 16'hACE1;
    end else if (ready) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign gnt      = data_req_i & ready & ~stall;
  assign in_range = (data_addr_i & ~WinMask) == BaseAddr;
  assign idx      = data_addr_i[MemAddrW+1:2];
  assign wr_en    = gnt & data_we_i & in_range;
  assign rd_en    = gnt & ~data_we_i & in_range;

  // Data array: contents are never reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Every in-range store rewrites the tag (even with be=0); non-cap stores clear it.
  cheri_dmem_tagarray #(
    .AddrW (MemAddrW)
  ) u_tagarray (
    .clk_i     (clk_i),
    .clr_en_i  (~ready),
    .clr_idx_i (sweep_idx_q),
    .we_i      (wr_en),
    .widx_i    (idx),
    .wtag_i    (data_is_cap_i & data_wdata_i[32]),
    .ridx_i    (idx),
    .rtag_o    (rtag)
  );

  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = gnt;
    if (gnt && !in_range) begin
      rsp_d.err = 1'b1;
    end else if (rd_en) begin
      rsp_d.rdata = {rtag & data_is_cap_i, mem_q[idx]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Latency; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= rsp_d;
      for (int unsigned i = 1; i < Latency; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign data_gnt_o        = gnt;
  assign data_rvalid_o     = pipe_q[LastStage].valid;
  assign data_err_o        = pipe_q[LastStage].err;
  assign data_rdata_o      = pipe_q[LastStage].rdata;
  assign data_rdata_intg_o = '0;
  assign init_done_o       = init_done_q;

endmodule

// File: tb/tb_cheri_dmem_responder.sv
module tb_cheri_dmem_responder;

  localparam int unsigned MEM_AW   = 4;
  localparam int unsigned LAT      = 3;
  localparam int unsigned WORDS    = 1 << MEM_AW;
  localparam logic [31:0] BASE     = 32'h2000_0000;
  localparam logic [31:0] WIN_MASK = (32'd1 << (MEM_AW + 2)) - 32'd1;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [32:0] wdata;
  logic        is_cap;
  logic        rvalid;
  logic [32:0] rdata;
  logic [6:0]  intg;
  logic        err;
  logic        init_done;

  cheri_dmem_responder #(
    .MemAddrW (MEM_AW),
    .BaseAddr (BASE),
    .Latency  (LAT)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .data_req_i        (req),
    .data_gnt_o        (gnt),
    .data_we_i         (we),
    .data_be_i         (be),
    .data_addr_i       (addr),
    .data_wdata_i      (wdata),
    .data_is_cap_i     (is_cap),
    .data_rvalid_o     (rvalid),
    .data_rdata_o      (rdata),
    .data_rdata_intg_o (intg),
    .data_err_o        (err),
    .init_done_o       (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [32:0] rdata;
    logic        err;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mdata [WORDS];
  logic        mtag  [WORDS];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned stall_cycles = 0;

  // Response monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && init_done && req && !gnt) stall_cycles++;
    if (rst_n && rvalid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid cycle %0d rdata=%h err=%b, no request outstanding", cyc, rdata, err);
      end else begin
        mon_e = sb.pop_front();
        if (rdata !== mon_e.rdata) begin
          errors++;
          $display("FAIL rsp_rdata cycle %0d got %h required %h", cyc, rdata, mon_e.rdata);
        end
        checks++;
        if (err !== mon_e.err) begin
          errors++;
          $display("FAIL rsp_err cycle %0d got %b required %b", cyc, err, mon_e.err);
        end
        checks++;
        if (cyc !== mon_e.due) begin
          errors++;
          $display("FAIL rsp_latency got cycle %0d required %0d", cyc, mon_e.due);
        end
        checks++;
        if (intg !== 7'd0) begin
          errors++;
          $display("FAIL rsp_intg got %h required 0", intg);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Called just after a rising edge; returns just after the edge following the grant.
  task automatic access(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [32:0] d, input logic c, output int unsigned gcyc);
    int unsigned      waits;
    logic [MEM_AW-1:0] ix;
    exp_t             e;
    req = 1'b1; we = w; be = b; addr = a; wdata = d; is_cap = c;
    waits = 0;
    gcyc  = 0;
    forever begin
      @(negedge clk);
      if (gnt) break;
      waits++;
      if (waits > 64) begin
        checks++;
        errors++;
        $display("FAIL grant_timeout addr=%h waited %0d cycles, required a grant", a, waits);
        @(posedge clk); #1;
        req = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    gcyc    = cyc;
    ix      = a[MEM_AW+1:2];
    e.due   = cyc + LAT;
    e.err   = 1'b0;
    e.rdata = '0;
    if ((a & ~WIN_MASK) != BASE) begin
      e.err = 1'b1;
    end else if (w) begin
      for (int i = 0; i < 4; i++) if (b[i]) mdata[ix][8*i +: 8] = d[8*i +: 8];
      mtag[ix] = c ? d[32] : 1'b0;
    end else begin
      e.rdata = {mtag[ix] & c, mdata[ix]};
    end
    sb.push_back(e);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < LAT + 8) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain %0d responses missing, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0; is_cap = 1'b0;
    for (int i = 0; i < WORDS; i++) mtag[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b required 0", gnt); end
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b required 0", rvalid); end
    checks++;
    if ({rdata, err} !== 34'd0) begin errors++; $display("FAIL reset_rdata_err got %h/%b required 0/0", rdata, err); end
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b required 0", init_done); end
    checks++;
    if (intg !== 7'd0) begin errors++; $display("FAIL reset_intg got %h required 0", intg); end
    // Request held across INIT (out-of-range load, so its response is fully known).
    req = 1'b1; addr = 32'h3000_0000;
    rst_n = 1'b1;
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 1'b0) begin errors++; $display("FAIL init_gnt cycle %0d got %b required 0", i, gnt); end
      checks++;
      if (init_done !== 1'b0) begin errors++; $display("FAIL init_done_early cycle %0d got %b required 0", i, init_done); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_late got %b required 1", init_done); end
    checks++;
    if (gnt !== 1'b1) begin
      errors++;
      $display("FAIL first_ready_gnt got %b required 1", gnt);
    end else begin
      e.rdata = '0; e.err = 1'b1; e.due = cyc + LAT;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req = 1'b0;
    drain();
  endtask

  task automatic test_cap_store_load();
    int unsigned g;
    access(1'b1, 4'hF, 32'h2000_0010, 33'h1_DEADBEEF, 1'b1, g);
    access(1'b0, 4'h0, 32'h2000_0010, 33'h0, 1'b1, g);
    access(1'b0, 4'h0, 32'h2000_0010, 33'h0, 1'b0, g);
    drain();
  endtask

  task automatic test_byte_store();
    int unsigned g;
    access(1'b1, 4'hF, 32'h2000_0010, 33'h1_DEADBEEF, 1'b1, g);
    access(1'b1, 4'b0001, 32'h2000_0010, 33'h0_00000055, 1'b0, g);
    access(1'b0, 4'h0, 32'h2000_0010, 33'h0, 1'b1, g);
    // be=0 cap store still rewrites the tag, data untouched.
    access(1'b1, 4'hF, 32'h2000_0014, 33'h1_12345678, 1'b1, g);
    access(1'b1, 4'h0, 32'h2000_0014, 33'h0_FFFFFFFF, 1'b1, g);
    access(1'b0, 4'h0, 32'h2000_0014, 33'h0, 1'b1, g);
    access(1'b1, 4'h0, 32'h2000_0014, 33'h1_FFFFFFFF, 1'b1, g);
    access(1'b0, 4'h0, 32'h2000_0017, 33'h0, 1'b1, g);
    drain();
  endtask

  task automatic test_out_of_range();
    int unsigned g;
    access(1'b0, 4'h0, 32'h3000_0000, 33'h0, 1'b1, g);
    access(1'b1, 4'hF, 32'h2000_0050, 33'h1_AAAAAAAA, 1'b1, g);
    access(1'b1, 4'hF, 32'h1FFF_FFFC, 33'h1_BBBBBBBB, 1'b1, g);
    access(1'b0, 4'h0, 32'h2000_0010, 33'h0, 1'b1, g);
    access(1'b0, 4'h0, 32'h2000_0014, 33'h0, 1'b1, g);
    drain();
  endtask

  task automatic test_back_to_back();
    int unsigned g [4];
    for (int i = 0; i < 4; i++)
      access(1'b1, 4'hF, BASE + 32'(i * 4), {1'b1, 32'h1111_0000 + 32'(i)}, 1'b1, g[0]);
    drain();
    for (int i = 0; i < 4; i++)
      access(1'b0, 4'h0, BASE + 32'(i * 4), 33'h0, 1'b1, g[i]);
`ifndef CHERI_DMEM_RAND_STALL_EN
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (g[i] !== g[0] + i) begin
        errors++;
        $display("FAIL b2b_grant load %0d granted cycle %0d required %0d", i, g[i], g[0] + i);
      end
    end
`endif
    drain();
  endtask

  task automatic test_reset_midop();
    int unsigned g;
    int unsigned n;
    access(1'b1, 4'hF, 32'h2000_0018, 33'h1_CAFEF00D, 1'b1, g);
    access(1'b0, 4'h0, BASE, 33'h0, 1'b1, g);
    access(1'b0, 4'h0, BASE + 32'd4, 33'h0, 1'b1, g);
    access(1'b0, 4'h0, BASE + 32'd8, 33'h0, 1'b1, g);
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < WORDS; i++) mtag[i] = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL midreset_rvalid got %b required 0", rvalid); end
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("FAIL midreset_init_done got %b required 0", init_done); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (init_done || n > 64) break;
      n++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checks++;
    if (n !== WORDS) begin errors++; $display("FAIL resweep_length got %0d cycles required %0d", n, WORDS); end
    access(1'b0, 4'h0, 32'h2000_0018, 33'h0, 1'b1, g);
    access(1'b0, 4'h0, 32'h2000_0004, 33'h0, 1'b0, g);
    drain();
  endtask

  task automatic test_random();
    int unsigned      g;
    int unsigned      r;
    logic [31:0]      a;
    logic [32:0]      d;
    for (int i = 0; i < WORDS; i++)
      access(1'b1, 4'hF, BASE + 32'(i * 4), {1'($urandom_range(0, 1)), $urandom()}, 1'b1, g);
    for (int k = 0; k < 1000; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'h3000_0000 | (32'($urandom_range(0, 255)) << 2);
      else if (r == 1) a = BASE + 32'h40 + (32'($urandom_range(0, 15)) << 2);
      else             a = BASE + (32'($urandom_range(0, WORDS - 1)) << 2) + 32'($urandom_range(0, 3));
      d = {1'($urandom_range(0, 1)), $urandom()};
      access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, d, 1'($urandom_range(0, 1)), g);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    checks++;
`ifdef CHERI_DMEM_RAND_STALL_EN
    if (stall_cycles == 0) begin
      errors++;
      $display("FAIL stall_seen got %0d stalled cycles required at least 1", stall_cycles);
    end
`else
    if (stall_cycles != 0) begin
      errors++;
      $display("FAIL no_stall got %0d stalled cycles required 0", stall_cycles);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_cap_store_load();
    test_byte_store();
    test_out_of_range();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
